// File: rtl/stream_checker_pkg.sv
// Shared types and constants for the stream checker: FSM states and check2 rule selectors.
package stream_checker_pkg;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } state_e;

    localparam int MODE_SUM = 0;
    localparam int MODE_EQ  = 1;

endpackage

// File: rtl/stream_checker_frame_accum.sv
// Per-word running sum and all-equal tracking; outputs reflect the frame including the word offered now.
module frame_accum #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              wordValid,
    input  logic              frameStart,
    input  logic [DATA_W-1:0] dataIn,
    output logic              sumZero,
    output logic              allEqual
);

    logic [DATA_W-1:0] sumQ, sumD;
    logic [DATA_W-1:0] firstQ, firstD;
    logic              allEqQ, allEqD;

    // A frame's first word restarts both trackers, so nothing leaks from the previous frame.
    always_comb begin
        sumD   = (frameStart ? '0 : sumQ) + dataIn;
        firstD = frameStart ? dataIn : firstQ;
        allEqD = frameStart ? 1'b1 : (allEqQ && (dataIn == firstQ));
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            sumQ   <= '0;
            firstQ <= '0;
            allEqQ <= 1'b0;
        end else if (wordValid) begin
            sumQ   <= sumD;
            firstQ <= firstD;
            allEqQ <= allEqD;
        end
    end

    assign sumZero  = (sumD == '0);
    assign allEqual = allEqD;

endmodule

// File: rtl/stream_checker.sv
// Frame assembler and checker: shifts DEPTH words into a frame, then reports parity and a MODE rule for one cycle.
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int MODE   = 0
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    inValid,
    input  logic [DATA_W-1:0]       dataIn,
    output logic                    outValid,
    output logic                    check1,
    output logic                    check2,
    output logic [DATA_W*DEPTH-1:0] checkData,
    output logic                    overrun
);

    localparam int CNT_W   = $clog2(DEPTH);
    localparam int FRAME_W = DATA_W * DEPTH;

    state_e               stateQ, stateD;
    logic [CNT_W-1:0]     countQ, countD;
    logic [FRAME_W-1:0]   frameQ, frameD;
    logic                 check1Q, check1D;
    logic                 check2Q, check2D;
    logic                 overrunQ, overrunD;

    logic accept;
    logic lastWord;
    logic sumZero;
    logic allEqual;

    assign accept   = (stateQ == FILL) && inValid;
    assign lastWord = accept && (countQ == CNT_W'(DEPTH - 1));

    frame_accum #(
        .DATA_W (DATA_W)
    ) u_accum (
        .clock      (clock),
        .clear      (clear),
        .wordValid  (accept),
        .frameStart (countQ == '0),
        .dataIn     (dataIn),
        .sumZero    (sumZero),
        .allEqual   (allEqual)
    );

    // Checks are captured only on the edge that completes a frame and hold until the next one.
    always_comb begin
        stateD   = stateQ;
        countD   = countQ;
        frameD   = frameQ;
        check1D  = check1Q;
        check2D  = check2Q;
        overrunD = overrunQ;

        case (stateQ)
            FILL: begin
                if (accept) begin
                    frameD = {frameQ[FRAME_W-DATA_W-1:0], dataIn};
                    if (lastWord) begin
                        countD  = '0;
                        stateD  = DONE;
                        check1D = ^frameD;
                        check2D = (MODE == MODE_SUM) ? sumZero : allEqual;
                    end else begin
                        countD = countQ + 1'b1;
                    end
                end
            end
            DONE: begin
                stateD = FILL;
                if (inValid) begin
                    overrunD = 1'b1;
                end
            end
            default: stateD = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            stateQ   <= FILL;
            countQ   <= '0;
            frameQ   <= '0;
            check1Q  <= 1'b0;
            check2Q  <= 1'b0;
            overrunQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            countQ   <= countD;
            frameQ   <= frameD;
            check1Q  <= check1D;
            check2Q  <= check2D;
            overrunQ <= overrunD;
        end
    end

    assign outValid  = (stateQ == DONE);
    assign check1    = check1Q;
    assign check2    = check2Q;
    assign checkData = frameQ;
    assign overrun   = overrunQ;

endmodule

// File: tb/tb_stream_checker.sv
// Randomized scoreboard bench driving a MODE 0 and a MODE 1 checker side by side against a word-list model.
module tb_stream_checker;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        inValid = 1'b0;
    logic [7:0]  dataIn = 8'h00;

    logic        outValid0, check1_0, check2_0, overrun0;
    logic        outValid1, check1_1, check2_1, overrun1;
    logic [63:0] checkData0, checkData1;

    stream_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MODE(0)) dutSum (
        .clock     (clock),
        .clear     (clear),
        .inValid   (inValid),
        .dataIn    (dataIn),
        .outValid  (outValid0),
        .check1    (check1_0),
        .check2    (check2_0),
        .checkData (checkData0),
        .overrun   (overrun0)
    );

    stream_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MODE(1)) dutEq (
        .clock     (clock),
        .clear     (clear),
        .inValid   (inValid),
        .dataIn    (dataIn),
        .outValid  (outValid1),
        .check1    (check1_1),
        .check2    (check2_1),
        .checkData (checkData1),
        .overrun   (overrun1)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] frame;
        bit          parity;
        bit          sumIsZero;
        bit          allSame;
    } expect_t;

    expect_t     expQ[$];
    int          errors = 0;
    int          checks = 0;
    bit          monEn = 1'b0;

    // reference model state: words of the frame in progress and observable held values
    int unsigned words[$];
    bit          dropNext = 1'b0;
    bit          mOverrun = 1'b0;
    logic [63:0] mShift = '0;
    bit          mCheck1 = 1'b0;
    bit          mCheckSum = 1'b0;
    bit          mCheckEq = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic expect_t completeFrame();
        expect_t     e;
        int unsigned sum = 0;
        e.frame   = '0;
        e.allSame = 1'b1;
        foreach (words[i]) begin
            e.frame = (e.frame << 8) | 64'(words[i]);
            sum     = sum + words[i];
            if (words[i] != words[0]) e.allSame = 1'b0;
        end
        e.parity    = ^e.frame;
        e.sumIsZero = ((sum % 256) == 0);
        return e;
    endfunction

    task automatic modelStep();
        expect_t e;
        if (clear) begin
            words.delete();
            dropNext  = 1'b0;
            mOverrun  = 1'b0;
            mShift    = '0;
            mCheck1   = 1'b0;
            mCheckSum = 1'b0;
            mCheckEq  = 1'b0;
            monEn     = 1'b1;
        end else if (dropNext) begin
            dropNext = 1'b0;
            if (inValid) mOverrun = 1'b1;
        end else if (inValid) begin
            words.push_back(int'(dataIn));
            mShift = {mShift[55:0], dataIn};
            if (words.size() == DEPTH) begin
                e         = completeFrame();
                mCheck1   = e.parity;
                mCheckSum = e.sumIsZero;
                mCheckEq  = e.allSame;
                expQ.push_back(e);
                words.delete();
                dropNext = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input bit clr, input bit vld, input logic [7:0] d);
        @(negedge clock);
        clear   = clr;
        inValid = vld;
        dataIn  = d;
        @(posedge clock);
        modelStep();
    endtask

    // Monitor: held outputs every cycle, frame results whenever a checker signals completion.
    always @(negedge clock) begin
        expect_t e;
        if (monEn) begin
            checkOutput("overrun0", 64'(overrun0), 64'(mOverrun));
            checkOutput("overrun1", 64'(overrun1), 64'(mOverrun));
            checkOutput("checkData0", checkData0, mShift);
            checkOutput("checkData1", checkData1, mShift);
            checkOutput("check1_0", 64'(check1_0), 64'(mCheck1));
            checkOutput("check1_1", 64'(check1_1), 64'(mCheck1));
            checkOutput("check2_sum", 64'(check2_0), 64'(mCheckSum));
            checkOutput("check2_eq", 64'(check2_1), 64'(mCheckEq));
            if (outValid0 || outValid1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected outValid", 64'(1), 64'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outValid0", 64'(outValid0), 64'(1));
                    checkOutput("outValid1", 64'(outValid1), 64'(1));
                    checkOutput("frame0", checkData0, e.frame);
                    checkOutput("frame1", checkData1, e.frame);
                    checkOutput("parity", 64'(check1_0), 64'(e.parity));
                    checkOutput("sumZero", 64'(check2_0), 64'(e.sumIsZero));
                    checkOutput("allEqual", 64'(check2_1), 64'(e.allSame));
                end
            end else if (expQ.size() != 0) begin
                void'(expQ.pop_front());
                checkOutput("missing outValid", 64'(0), 64'(1));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] seq[8];
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hE4};

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'hAA);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, (i == 4) ? 8'hAB : 8'hAA);
        applyStimulus(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 8; i++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) applyStimulus(1'b0, 1'b0, 8'($urandom));
            applyStimulus(1'b0, 1'b1, seq[i]);
        end
        applyStimulus(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, 8'(8'h20 + i));
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h33);
        applyStimulus(1'b1, 1'b1, 8'h44);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h11);
        applyStimulus(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 149) == 0,
                          $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h5A);
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("queue drained", 64'(expQ.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
